// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the instruction-memory request/response channel, the
//               redirect input and the downstream instruction channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic [6:0]      op_code;

    // Fetch-unit side
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, op_code,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, inst_ready
    );

    // Memory / decoder / execute side
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, op_code,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with in-order memory responses, a small
//               response FIFO and redirect-driven flush of in-flight fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam logic [CW1-1:0] c_DEPTH = CW1'(DEPTH);
    localparam logic [PW-1:0]  c_LAST  = PW'(DEPTH - 1);

    localparam logic [1:0] c_ST_BOOT  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_mem_data [DEPTH];
    logic [XLEN-1:0] r_mem_pc   [DEPTH];

    logic            w_req_valid;
    logic            w_req_hs;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_pop;
    logic [CW1-1:0]  w_occupancy;
    logic [CW-1:0]   w_drop_next;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_inst_data;

    // Occupancy counts both buffered words and requests still in flight, so a
    // FIFO slot is always reserved for every response that will be kept.
    assign w_occupancy = CW1'(r_outstanding) + CW1'(r_count);
    assign w_req_valid = (r_state != c_ST_BOOT) && (w_occupancy < c_DEPTH);
    assign w_req_hs    = w_req_valid && bus.imem_req_ready;
    assign w_rsp_drop  = (r_drop_cnt != '0);
    assign w_push      = bus.imem_rsp_valid && !w_rsp_drop && !bus.redirect;
    assign w_pop       = (r_count != '0) && bus.inst_ready;
    assign w_target    = {bus.redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        w_drop_next = r_drop_cnt;
        if (bus.redirect) begin
            w_drop_next = r_outstanding + CW'(w_req_hs) - CW'(bus.imem_rsp_valid);
        end else if (bus.imem_rsp_valid && w_rsp_drop) begin
            w_drop_next = r_drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else begin
            case (r_state)
                c_ST_BOOT: r_state <= c_ST_RUN;
                default:   r_state <= (w_drop_next != '0) ? c_ST_FLUSH : c_ST_RUN;
            endcase

            r_drop_cnt    <= w_drop_next;
            r_outstanding <= r_outstanding + CW'(w_req_hs) - CW'(bus.imem_rsp_valid);

            if (bus.redirect) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_req_hs) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_push) begin
                    r_mem_data[r_wr_ptr] <= bus.imem_rsp_data;
                    r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
                    r_rsp_pc             <= r_rsp_pc + XLEN'(4);
                    r_wr_ptr             <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Empty FIFO presents zeros so the decoder never sees a stale word.
    assign w_inst_data        = (r_count != '0) ? r_mem_data[r_rd_ptr] : '0;
    assign bus.inst_pc        = (r_count != '0) ? r_mem_pc[r_rd_ptr] : '0;
    assign bus.inst_data      = w_inst_data;
    assign bus.op_code        = w_inst_data[6:0];
    assign bus.inst_valid     = (r_count != '0);
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized bench for fetch_unit with an epoch-based reference
//               model of the expected instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference state: every request carries the epoch it was issued in; a
    // redirect opens a new epoch, and only current-epoch words reach the decoder.
    mreq_t       mem_q[$];
    ent_t        fifo_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] req_log[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    logic        m_boot = 1'b1;
    int          m_epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          since_rst = 0;
    int          first_valid = -1;
    int          n_req = 0;

    int          p_ready = 100;
    int          p_inst = 100;
    int          p_redir = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0;
    logic        arm4 = 1'b0;
    logic        hit4 = 1'b0;
    logic [31:0] hit4_pc = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(3))
            0:       return 32'h0000_0100;
            1:       return 32'hFFFF_FFFE;
            2:       return 32'h0000_0042;
            default: return $urandom;
        endcase
    endfunction

    task automatic cycle();
        logic  rsp, redir, use_force, exp_rv, hs, pop;
        mreq_t r;
        ent_t  e;
        int    due;
        @(negedge clk);
        bus.imem_req_ready = ($urandom_range(99) < p_ready);
        bus.inst_ready     = ($urandom_range(99) < p_inst);
        rsp = (mem_q.size() > 0) && (mem_q[0].due == cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? (mem_q[0].addr ^ KEY) : $urandom;
        use_force = force_redir;
        redir = !m_boot && (force_redir || ($urandom_range(99) < p_redir));
        if (arm4 && fifo_q.size() > 0 && bus.inst_ready && rsp) begin
            redir     = 1'b1;
            use_force = 1'b1;
            arm4      = 1'b0;
            hit4      = 1'b1;
            hit4_pc   = fifo_q[0].pc;
        end
        bus.redirect    = redir;
        bus.redirect_pc = use_force ? force_pc : pick_pc();
        force_redir     = 1'b0;
        #1;
        exp_rv = !m_boot && ((mem_q.size() + fifo_q.size()) < DEPTH);
        check_val("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) check_val("req_addr", bus.imem_req_addr, m_fetch_pc);
        check_val("inst_valid", 32'(bus.inst_valid), 32'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            check_val("inst_pc", bus.inst_pc, fifo_q[0].pc);
            check_val("inst_data", bus.inst_data, fifo_q[0].data);
            check_val("op_code", 32'(bus.op_code), 32'(fifo_q[0].data[6:0]));
        end
        if (bus.inst_valid && first_valid < 0) first_valid = since_rst;

        hs  = exp_rv && bus.imem_req_ready;
        pop = (fifo_q.size() != 0) && bus.inst_ready;
        if (pop) begin
            e = fifo_q.pop_front();
            pop_log.push_back(e.pc);
        end
        if (rsp) begin
            r = mem_q.pop_front();
            if (r.epoch == m_epoch && !redir) begin
                e.pc   = r.addr;
                e.data = r.addr ^ KEY;
                fifo_q.push_back(e);
            end
        end
        if (hs) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            r.addr  = m_fetch_pc;
            r.epoch = m_epoch;
            r.due   = due;
            mem_q.push_back(r);
            last_due = due;
            req_log.push_back(m_fetch_pc);
            n_req++;
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redir) begin
            fifo_q.delete();
            m_fetch_pc = {bus.redirect_pc[31:2], 2'b00};
            m_epoch++;
        end
        m_boot = 1'b0;
        cyc++;
        since_rst++;
    endtask

    // Reset is asserted mid-cycle so its effect on outputs must be asynchronous.
    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        bus.redirect       = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        #1;
        check_val("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check_val("rst_req_addr", bus.imem_req_addr, RESET_PC);
        check_val("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        check_val("rst_inst_data", bus.inst_data, 32'h0);
        check_val("rst_inst_pc", bus.inst_pc, 32'h0);
        check_val("rst_op_code", 32'(bus.op_code), 32'h0);
        mem_q.delete();
        fifo_q.delete();
        m_fetch_pc  = RESET_PC;
        m_boot      = 1'b1;
        m_epoch++;
        last_due    = cyc;
        since_rst   = 0;
        first_valid = -1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic reach_two_outstanding(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cycle();
            if (mem_q.size() == 2) ok = 1'b1;
        end
        check_val(tag, 32'(ok), 32'h1);
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;

        // Straight-line fetch, 1-cycle memory
        do_reset();
        pop_log.delete();
        repeat (12) cycle();
        check_val("t1_first_valid", 32'(first_valid), 32'd3);
        check_val("t1_pop0", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);
        check_val("t1_pop1", (pop_log.size() > 1) ? pop_log[1] : 32'hDEAD_BEEF, 32'h4);
        check_val("t1_pop2", (pop_log.size() > 2) ? pop_log[2] : 32'hDEAD_BEEF, 32'h8);

        // Decoder stall limits issue to DEPTH requests
        do_reset();
        p_inst = 0;
        n_req  = 0;
        req_log.delete();
        repeat (10) cycle();
        check_val("t2_req_count", 32'(n_req), 32'd2);
        check_val("t2_req0", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h0);
        check_val("t2_req1", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'h4);
        p_inst = 100;
        pop_log.delete();
        repeat (10) cycle();
        check_val("t2_drain0", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);
        check_val("t2_drain1", (pop_log.size() > 1) ? pop_log[1] : 32'hDEAD_BEEF, 32'h4);
        check_val("t2_drain2", (pop_log.size() > 2) ? pop_log[2] : 32'hDEAD_BEEF, 32'h8);

        // Redirect with two fetches in flight, 3-cycle memory
        lat_min = 3;
        lat_max = 3;
        reach_two_outstanding("t3_setup");
        force_redir = 1'b1;
        force_pc    = 32'h0000_0100;
        cycle();
        pop_log.delete();
        repeat (20) cycle();
        check_val("t3_pop0", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);
        check_val("t3_pop1", (pop_log.size() > 1) ? pop_log[1] : 32'hDEAD_BEEF, 32'h104);

        // Redirect coinciding with decoder handshake and an arriving response
        lat_min  = 1;
        lat_max  = 1;
        force_pc = 32'h0000_0300;
        hit4     = 1'b0;
        arm4     = 1'b1;
        for (int i = 0; i < 50 && !hit4; i++) begin
            pop_log.delete();
            cycle();
        end
        arm4 = 1'b0;
        check_val("t4_hit", 32'(hit4), 32'h1);
        check_val("t4_kept", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, hit4_pc);
        pop_log.delete();
        repeat (10) cycle();
        check_val("t4_next", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h300);

        // Misaligned redirect near the top of the address space
        lat_max     = 2;
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFFE;
        cycle();
        req_log.delete();
        pop_log.delete();
        repeat (12) cycle();
        check_val("t5_req0", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check_val("t5_req1", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'h0);
        check_val("t5_pop0", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check_val("t5_pop1", (pop_log.size() > 1) ? pop_log[1] : 32'hDEAD_BEEF, 32'h0);

        // Reset while flushing two outstanding fetches
        lat_min = 3;
        lat_max = 3;
        reach_two_outstanding("t6_setup");
        force_redir = 1'b1;
        force_pc    = 32'h0000_0200;
        cycle();
        do_reset();
        req_log.delete();
        repeat (4) cycle();
        check_val("t6_restart", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, RESET_PC);

        // Randomized traffic with stalls, variable latency and redirects
        p_ready = 70;
        p_inst  = 70;
        p_redir = 4;
        lat_min = 1;
        lat_max = 4;
        repeat (1500) cycle();
        do_reset();
        repeat (500) cycle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
`default_nettype wire
